// File: rtl/divider_programmable_pkg.sv
// Shared types and constants for the programmable clock divider.
package divider_programmable_pkg;

    // Top-level sequencing: stopped, running, finishing the current period.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Smallest ratio that still yields a real high and a real low phase.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/divider_programmable_if.sv
// Control/status bundle of the programmable divider.
interface divider_programmable_if #(
    parameter int W = 8
);
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         div_ack;
    logic         clkout;
    logic         tick;
    logic         running;
    logic         ratio_err;

    // Divider side.
    modport slave (
        input  en, div_in, div_load,
        output div_ack, clkout, tick, running, ratio_err
    );

    // Controller side.
    modport master (
        output en, div_in, div_load,
        input  div_ack, clkout, tick, running, ratio_err
    );
endinterface

// File: rtl/divider_ratio_shadow.sv
// Shadow/active ratio pair: loads are clamped and parked in the shadow
// register, and only move to the active ratio when the sequencer says a
// period boundary (or idle) allows it.
module divider_ratio_shadow
    import divider_programmable_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clkin,
    input  logic         rst_n,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
    input  logic         apply,
    output logic [W-1:0] active,
    output logic         pending,
    output logic         div_ack,
    output logic         ratio_err
);

    logic [W-1:0] shadow;

    // Apply uses the old shadow; a load on the same edge re-arms pending
    // with the new value, so it waits for the following boundary.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            active    <= W'(DEFAULT_DIV);
            shadow    <= W'(DEFAULT_DIV);
            pending   <= 1'b0;
            div_ack   <= 1'b0;
            ratio_err <= 1'b0;
        end else begin
            div_ack <= apply;
            if (apply) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (div_load) begin
                pending <= 1'b1;
                if (div_in < W'(MIN_DIV)) begin
                    shadow    <= W'(MIN_DIV);
                    ratio_err <= 1'b1;
                end else begin
                    shadow <= div_in;
                end
            end
        end
    end

endmodule

// File: rtl/divider_programmable.sv
// Programmable integer clock divider: registered near-50% clkout, a tick
// strobe on the last cycle of each period, and ratio changes that only take
// effect on period boundaries.
module divider_programmable
    import divider_programmable_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    divider_programmable_if.slave bus
);

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n;
    logic [W-1:0] active, r_m1, high_len;
    logic         clkout_q, clkout_n;
    logic         tick_q, tick_n;
    logic         pending, apply, boundary;
    logic         div_ack, ratio_err;

    divider_ratio_shadow #(
        .W           (W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_shadow (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .div_in    (bus.div_in),
        .div_load  (bus.div_load),
        .apply     (apply),
        .active    (active),
        .pending   (pending),
        .div_ack   (div_ack),
        .ratio_err (ratio_err)
    );

    assign r_m1     = active - W'(1);
    assign high_len = active - (active >> 1);
    // >= rather than == so a stray counter value wraps instead of running on.
    assign boundary = (cnt >= r_m1);

    // Next state, next count and the registered output values derived from
    // the next count. A boundary always restarts at 0, where clkout is high
    // and tick low whatever the new ratio, so the old ratio is safe to use.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        apply   = 1'b0;
        case (state)
            IDLE: begin
                apply = pending;
                if (bus.en) state_n = RUN;
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    if (bus.en) begin
                        state_n = RUN;
                        apply   = pending;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n   = cnt + W'(1);
                    state_n = bus.en ? RUN : DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
        clkout_n = (state_n != IDLE) && (cnt_n < high_len);
        tick_n   = (state_n != IDLE) && (cnt_n == r_m1);
    end

    // State, counter and output registers; reset drops clkout immediately.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            clkout_q <= clkout_n;
            tick_q   <= tick_n;
        end
    end

    assign bus.clkout    = clkout_q;
    assign bus.tick      = tick_q;
    assign bus.running   = (state != IDLE);
    assign bus.div_ack   = div_ack;
    assign bus.ratio_err = ratio_err;

endmodule

// File: tb/tb_divider_programmable.sv
// Self-checking bench for divider_programmable: directed test-plan steps
// followed by random traffic, all checked against a period-level model.
module tb_divider_programmable;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    divider_programmable_if #(.W(8)) bus ();

    divider_programmable #(.W(8), .DEFAULT_DIV(4)) dut (
        .clkin (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: while a period is in flight, the queues hold the clkout/tick
    // values of its remaining cycles (front = current cycle).
    bit m_on;
    bit m_qc[$];
    bit m_qt[$];
    int m_ratio, m_shadow;
    bit m_pend, m_err, m_ack;

    task automatic fill_period();
        for (int i = 0; i < m_ratio; i++) begin
            m_qc.push_back(i < (m_ratio - m_ratio / 2));
            m_qt.push_back(i == m_ratio - 1);
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, check all outputs.
    task automatic step(input bit e, input bit ld, input logic [7:0] d, input bit rn);
        bit ack_n;
        bus.en = e; bus.div_load = ld; bus.div_in = d; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            m_on = 0; m_qc.delete(); m_qt.delete();
            m_ratio = 4; m_shadow = 4; m_pend = 0; m_err = 0; m_ack = 0;
        end else begin
            ack_n = 0;
            if (!m_on) begin
                if (m_pend) begin m_ratio = m_shadow; m_pend = 0; ack_n = 1; end
                if (e) begin m_on = 1; fill_period(); end
            end else begin
                m_qc.delete(0); m_qt.delete(0);
                if (m_qc.size() == 0) begin
                    if (e) begin
                        if (m_pend) begin m_ratio = m_shadow; m_pend = 0; ack_n = 1; end
                        fill_period();
                    end else begin
                        m_on = 0;
                    end
                end
            end
            if (ld) begin
                if (d < 8'd2) begin m_shadow = 2; m_err = 1; end
                else m_shadow = int'(d);
                m_pend = 1;
            end
            m_ack = ack_n;
        end
        #1;
        check("clkout",    bus.clkout,    m_on ? m_qc[0] : 1'b0);
        check("tick",      bus.tick,      m_on ? m_qt[0] : 1'b0);
        check("running",   bus.running,   m_on);
        check("div_ack",   bus.div_ack,   m_ack);
        check("ratio_err", bus.ratio_err, m_err);
    endtask

    task automatic run(input int n, input bit e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 8'd0, 1'b1);
    endtask

    // Run with en=1 until the model sits in the cycle with `rem` cycles left.
    task automatic run_until(input int rem);
        int n = 0;
        while (!(m_on && m_qc.size() == rem) && n < 64) begin
            step(1'b1, 1'b0, 8'd0, 1'b1);
            n++;
        end
        checks++;
        assert (n < 64) else begin
            errors++;
            $error("FAIL align_timeout observed=%0d expected<64", n);
        end
    endtask

    logic [7:0] pc, pt;

    initial begin
        bus.en = 0; bus.div_load = 0; bus.div_in = '0; rst_n = 0;

        // Reset state.
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_clkout",  bus.clkout,  1'b0);
        check("rst_running", bus.running, 1'b0);

        // R=4 from reset: 1100 / 0001 repeating.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1);
            pc[7-i] = bus.clkout;
            pt[7-i] = bus.tick;
        end
        checks++;
        assert (pc === 8'b1100_1100) else begin
            errors++; $error("FAIL r4_clk_pattern observed=%b expected=11001100", pc);
        end
        checks++;
        assert (pt === 8'b0001_0001) else begin
            errors++; $error("FAIL r4_tick_pattern observed=%b expected=00010001", pt);
        end

        // Load 5 then 7 mid-period: only 7 is applied, one ack.
        run(2, 1);
        step(1, 1, 8'd5, 1);
        step(1, 1, 8'd7, 1);
        run(20, 1);

        // Out-of-range loads clamp to 2 and set the sticky error.
        step(1, 1, 8'd0, 1);
        step(1, 1, 8'd1, 1);
        run(14, 1);
        check("err_sticky", bus.ratio_err, 1'b1);

        // R=6, stop at cnt=1: period completes then idles.
        step(1, 1, 8'd6, 1);
        run(10, 1);
        run_until(5);
        run(10, 0);
        check("stop_idle", bus.running, 1'b0);

        // R=6, drop en at cnt=2, re-raise at cnt=4.
        run(3, 1);
        run_until(4);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        run(14, 1);

        // R=8, reset at cnt=3 while clkout is high.
        step(1, 1, 8'd8, 1);
        run(20, 1);
        run_until(5);
        check("pre_rst_high", bus.clkout, 1'b1);
        step(1, 0, 0, 0);
        check("mid_rst_low", bus.clkout, 1'b0);
        run(12, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit e, ld, rn;
            logic [7:0] d;
            e  = ($urandom_range(0, 9) == 0) ? ~bus.en : bus.en;
            ld = ($urandom_range(0, 11) == 0);
            d  = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 40))
                                              : 8'($urandom_range(0, 12));
            rn = ($urandom_range(0, 499) != 0);
            step(e, ld, d, rn);
        end

        // Only reset clears the error flag.
        step(0, 0, 0, 0);
        check("err_cleared", bus.ratio_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
